// File: rtl/pattern_det_prog.sv
// pattern_det_prog: programmable serial pattern detector with a saturating match counter.
// A PAT_LEN-bit window collects accepted bits; a match is registered when the
// full window equals the stored pattern. The pattern and the overlap mode are
// loaded at run time. Optional feature macro: PDET_MASK_EN adds a per-bit
// don't-care mask (mask_i) that is sampled together with the pattern.
module pattern_det_prog #(
    parameter int                 PAT_LEN = 5,
    parameter int                 CNT_W   = 8,
    parameter logic [PAT_LEN-1:0] PAT_RST = 5'b01101
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               d_i,
    input  logic               valid_i,
    input  logic               load_i,
    input  logic [PAT_LEN-1:0] pat_i,
    input  logic               overlap_i,
`ifdef PDET_MASK_EN
    input  logic [PAT_LEN-1:0] mask_i,
`endif
    input  logic               clr_cnt_i,
    output logic               pattern,
    output logic [CNT_W-1:0]   match_cnt_o,
    output logic               busy_o
);

    localparam int                FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] window;
    logic [PAT_LEN-1:0] window_next;
    logic [PAT_LEN-1:0] pat_q;
    logic [PAT_LEN-1:0] mask_q;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_inc;
    logic               overlap_q;
    logic               accept;
    logic               hit;

    // Post-shift window and fill for the bit offered this cycle, and the match decision.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path; here
        // all of them are plain unconditional assignments, so no latch can be inferred.
        accept      = valid_i & ~load_i;
        window_next = {window[PAT_LEN-2:0], d_i};
        fill_inc    = (fill == FULL) ? fill : fill + FILL_W'(1);
        hit         = accept
                      && (((window_next ^ pat_q) & ~mask_q) == '0)
                      && (fill_inc == FULL);
    end

    // Stored pattern and detection mode; load_i replaces them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q     <= PAT_RST;
            overlap_q <= 1'b1;
        end else if (load_i) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values, independent of block ordering.
            pat_q     <= pat_i;
            overlap_q <= overlap_i;
        end
    end

`ifdef PDET_MASK_EN
    // Don't-care mask, loaded alongside the pattern; a 1 ignores that bit position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
        end else if (load_i) begin
            mask_q <= mask_i;
        end
    end
`else
    assign mask_q = '0;
`endif

    // Shift window and fill: load clears, accepted bits shift in, gaps hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window <= '0;
            fill   <= '0;
        end else if (load_i) begin
            window <= '0;
            fill   <= '0;
        end else if (accept) begin
            window <= window_next;
            // Non-overlap mode restarts the fill so the next match needs all fresh bits.
            fill   <= (hit && !overlap_q) ? '0 : fill_inc;
        end
    end

    // Registered one-cycle match pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= 1'b0;
        end else begin
            pattern <= hit;
        end
    end

    // Saturating match counter; a clear wins over a coincident match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            match_cnt_o <= '0;
        end else if (hit && (match_cnt_o != '1)) begin
            match_cnt_o <= match_cnt_o + CNT_W'(1);
        end
    end

    assign busy_o = (fill < FULL);

endmodule

// File: tb/tb_pattern_det_prog.sv
// tb_pattern_det_prog: scoreboard bench for pattern_det_prog. The driver pushes
// the reference model's expected outputs after every clock edge; a monitor pops
// and compares them on the falling edge. Directed sequences, then random traffic.
module tb_pattern_det_prog;

    localparam int              PL      = 5;
    localparam int              CW      = 2;
    localparam logic [PL-1:0]   PAT_DEF = 5'b01101;
    localparam int              CNT_MAX = (1 << CW) - 1;

    typedef struct {
        bit pulse;
        int cnt;
        bit busy;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          d_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          load_i = 1'b0;
    logic [PL-1:0] pat_i = '0;
    logic          overlap_i = 1'b0;
    logic [PL-1:0] mask_i = '0;
    logic          clr_cnt_i = 1'b0;
    logic          pattern;
    logic [CW-1:0] match_cnt_o;
    logic          busy_o;

    int tests = 0;
    int fails = 0;
    int pulses_seen = 0;

    // Reference model: history of accepted bits since the last restart.
    bit            hist[$];
    logic [PL-1:0] m_pat;
    logic [PL-1:0] m_mask;
    bit            m_ovl;
    int            m_cnt;
    exp_t          sb[$];

    pattern_det_prog #(.PAT_LEN(PL), .CNT_W(CW), .PAT_RST(PAT_DEF)) dut (
        .clk         (clk),
        .rst         (rst),
        .d_i         (d_i),
        .valid_i     (valid_i),
        .load_i      (load_i),
        .pat_i       (pat_i),
        .overlap_i   (overlap_i),
`ifdef PDET_MASK_EN
        .mask_i      (mask_i),
`endif
        .clr_cnt_i   (clr_cnt_i),
        .pattern     (pattern),
        .match_cnt_o (match_cnt_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        m_pat  = PAT_DEF;
        m_mask = '0;
        m_ovl  = 1'b1;
        m_cnt  = 0;
    endfunction

    // Last PL accepted bits, oldest first, against pattern MSB first.
    function automatic bit model_match();
        if (hist.size() < PL) return 1'b0;
        for (int i = 0; i < PL; i++) begin
            if (!m_mask[PL-1-i] && (hist[i] != m_pat[PL-1-i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Drive one cycle, let the edge happen, then push the model's expectation.
    task automatic step(input bit v, input bit d, input bit ld, input bit clr,
                        input logic [PL-1:0] p, input bit ov, input logic [PL-1:0] mk);
        exp_t e;
        bit   hit;
        valid_i   = v;
        d_i       = d;
        load_i    = ld;
        clr_cnt_i = clr;
        pat_i     = p;
        overlap_i = ov;
        mask_i    = mk;
        @(posedge clk);
        hit = 1'b0;
        if (ld) begin
            m_pat = p;
            m_ovl = ov;
`ifdef PDET_MASK_EN
            m_mask = mk;
`endif
            hist.delete();
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() > PL) void'(hist.pop_front());
            hit = model_match();
            if (hit && !m_ovl) hist.delete();
        end
        if (clr) m_cnt = 0;
        else if (hit && m_cnt < CNT_MAX) m_cnt++;
        e.pulse = hit;
        e.cnt   = m_cnt;
        e.busy  = (hist.size() < PL);
        sb.push_back(e);
        #1;
        valid_i   = 1'b0;
        load_i    = 1'b0;
        clr_cnt_i = 1'b0;
    endtask

    task automatic bit_in(input bit d);
        step(1'b1, d, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic send_seq(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pattern === 1'b1) pulses_seen++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pattern", int'(pattern), int'(e.pulse));
                check("match_cnt", int'(match_cnt_o), e.cnt);
                check("busy", int'(busy_o), int'(e.busy));
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        model_reset();
        #12;
        check("rst_pattern", int'(pattern), 0);
        check("rst_cnt", int'(match_cnt_o), 0);
        check("rst_busy", int'(busy_o), 1);
        @(negedge clk);
        rst = 1'b0;

        // Default config, overlap: pulses after bits 5 and 8.
        base = pulses_seen;
        send_seq(16'b01101101, 8);
        settle();
        check("ovl_pulses", pulses_seen - base, 2);
        check("ovl_cnt", int'(match_cnt_o), 2);

        // Non-overlap: one pulse only.
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'b01101, 1'b0, '0);
        base = pulses_seen;
        send_seq(16'b01101101, 8);
        settle();
        check("novl_pulses", pulses_seen - base, 1);
        check("novl_cnt", int'(match_cnt_o), 1);

        // Gap of invalid cycles inside a sequence.
        base = pulses_seen;
        send_seq(16'b011, 3);
        repeat (3) idle();
        settle();
        check("gap_no_pulse", pulses_seen - base, 0);
        send_seq(16'b01, 2);
        settle();
        check("gap_pulse", pulses_seen - base, 1);

        // Counter saturation at CNT_W=2, then clear coincident with a match.
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'b01101, 1'b1, '0);
        base = pulses_seen;
        send_seq(16'b01101101101101, 14);
        send_seq(16'b101, 3);
        settle();
        check("sat_cnt", int'(match_cnt_o), 3);
        bit_in(1'b1);
        bit_in(1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, '0, 1'b0, '0);
        settle();
        check("clr_cnt", int'(match_cnt_o), 0);
        check("clr_pulses", pulses_seen - base, 6);

        // Load with simultaneous valid bit: bit is dropped.
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'b01101, 1'b1, '0);
        send_seq(16'b1101, 4);
        settle();
        check("load_drop_busy", int'(busy_o), 1);

        // Asynchronous reset mid-sequence.
        base = pulses_seen;
        send_seq(16'b0110, 4);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_pattern", int'(pattern), 0);
        check("arst_cnt", int'(match_cnt_o), 0);
        check("arst_busy", int'(busy_o), 1);
        #1;
        rst = 1'b0;
        bit_in(1'b1);
        settle();
        check("arst_no_pulse", pulses_seen - base, 0);

        // Masked compare: pulse only when the mask feature is built in.
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'b01101, 1'b1, 5'b00100);
        base = pulses_seen;
        send_seq(16'b01001, 5);
        settle();
`ifdef PDET_MASK_EN
        check("mask_pulse", pulses_seen - base, 1);
`else
        check("mask_pulse", pulses_seen - base, 0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit            ld;
            logic [PL-1:0] p;
            ld = ($urandom_range(99) < 2);
            p  = ($urandom_range(1)) ? PAT_DEF : PL'($urandom);
            step(($urandom_range(9) < 7), 1'($urandom), ld,
                 ($urandom_range(99) < 3), p, 1'($urandom), PL'($urandom & $urandom));
        end

        repeat (2) @(negedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
